// File: rtl/dmem_bus_adapter.sv
// Registered bridge from load/store controller strobes to a valid/ready data-memory bus.
// Optional REQ/WAIT timeout abort is enabled by defining DMEM_BUS_TIMEOUT_EN.
module dmem_bus_adapter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_cs,
    input  logic        i_wr,
    input  logic [3:0]  i_mask,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_data_wr,
    output logic [31:0] o_data_rd,
    output logic        o_stall,
    output logic        o_access_err,
    output logic        o_bus_req_valid,
    input  logic        i_bus_req_ready,
    output logic        o_bus_req_we,
    output logic [31:0] o_bus_req_addr,
    output logic [31:0] o_bus_req_wdata,
    output logic [3:0]  o_bus_req_be,
    input  logic        i_bus_rsp_valid,
    input  logic [31:0] i_bus_rsp_rdata,
    input  logic        i_bus_rsp_err
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

    state_e      r_state;
    logic        r_valid;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic [31:0] r_data_rd;
    logic        r_access_err;
    logic        w_acc;
    logic        w_timeout;
    logic        w_unused;

    assign w_acc = !i_cs && (i_wr || (i_mask != 4'b0000));

    // Gated by reset so that every output reads 0 while reset is held
    assign o_stall = i_rst_n && (((r_state == StIdle) && w_acc) ||
                                 (r_state == StReq) || (r_state == StWait));

`ifdef DMEM_BUS_TIMEOUT_EN
    localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (r_state == StIdle) begin
            r_cnt <= '0;
        end else if ((r_state == StReq) || (r_state == StWait)) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    // A handshake or response in the last allowed cycle still wins over the abort
    assign w_timeout = (r_cnt >= TimeoutLast);
    assign w_unused  = ^i_addr[1:0];
`else
    assign w_timeout = 1'b0;
    assign w_unused  = ^{i_addr[1:0], TIMEOUT_CYCLES};
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= StIdle;
            r_valid      <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_be         <= '0;
            r_data_rd    <= '0;
            r_access_err <= 1'b0;
        end else begin
            r_access_err <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (w_acc) begin
                        r_state <= StReq;
                        r_valid <= 1'b1;
                        r_we    <= !i_wr;
                        r_addr  <= {i_addr[31:2], 2'b00};
                        r_wdata <= i_data_wr;
                        r_be    <= i_wr ? 4'b1111 : i_mask;
                    end
                end
                StReq: begin
                    if (i_bus_req_ready) begin
                        r_state <= StWait;
                        r_valid <= 1'b0;
                    end else if (w_timeout) begin
                        r_state      <= StDone;
                        r_valid      <= 1'b0;
                        r_data_rd    <= '0;
                        r_access_err <= 1'b1;
                    end
                end
                StWait: begin
                    if (i_bus_rsp_valid) begin
                        r_state      <= StDone;
                        r_access_err <= i_bus_rsp_err;
                        if (i_bus_rsp_err) begin
                            r_data_rd <= '0;
                        end else if (!r_we) begin
                            r_data_rd <= i_bus_rsp_rdata;
                        end
                    end else if (w_timeout) begin
                        r_state      <= StDone;
                        r_data_rd    <= '0;
                        r_access_err <= 1'b1;
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign o_data_rd       = r_data_rd;
    assign o_access_err    = r_access_err;
    assign o_bus_req_valid = r_valid;
    assign o_bus_req_we    = r_we;
    assign o_bus_req_addr  = r_addr;
    assign o_bus_req_wdata = r_wdata;
    assign o_bus_req_be    = r_be;

endmodule

// File: tb/tb_dmem_bus_adapter.sv
// Self-checking bench for dmem_bus_adapter: directed vector table, random transactions
// against a transaction-level model, and hand-written reset/timeout sequences.
module tb_dmem_bus_adapter;

    localparam int unsigned TimeoutCycles = 4;
`ifdef DMEM_BUS_TIMEOUT_EN
    localparam int MaxDly = 2;
`else
    localparam int MaxDly = 5;
`endif

    typedef struct {
        logic        cs;
        logic        wr;
        logic [3:0]  mask;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          rdy_dly;
        int          rsp_dly;
        logic        err;
        logic [31:0] rdata;
        logic        exp_acc;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic        exp_we;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cs;
    logic        wr;
    logic [3:0]  mask;
    logic [31:0] addr;
    logic [31:0] data_wr;
    logic [31:0] data_rd;
    logic        stall;
    logic        access_err;
    logic        bus_req_valid;
    logic        bus_req_ready;
    logic        bus_req_we;
    logic [31:0] bus_req_addr;
    logic [31:0] bus_req_wdata;
    logic [3:0]  bus_req_be;
    logic        bus_rsp_valid;
    logic [31:0] bus_rsp_rdata;
    logic        bus_rsp_err;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] m_data_rd;
    vec_t        tbl[7];

    always #5 clk = ~clk;

    dmem_bus_adapter #(
        .TIMEOUT_CYCLES(TimeoutCycles)
    ) u_dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_cs           (cs),
        .i_wr           (wr),
        .i_mask         (mask),
        .i_addr         (addr),
        .i_data_wr      (data_wr),
        .o_data_rd      (data_rd),
        .o_stall        (stall),
        .o_access_err   (access_err),
        .o_bus_req_valid(bus_req_valid),
        .i_bus_req_ready(bus_req_ready),
        .o_bus_req_we   (bus_req_we),
        .o_bus_req_addr (bus_req_addr),
        .o_bus_req_wdata(bus_req_wdata),
        .o_bus_req_be   (bus_req_be),
        .i_bus_rsp_valid(bus_rsp_valid),
        .i_bus_rsp_rdata(bus_rsp_rdata),
        .i_bus_rsp_err  (bus_rsp_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Bus-side inputs that must have no effect in the current cycle
    task automatic junk_bus();
        bus_req_ready = 1'($urandom_range(0, 1));
        bus_rsp_valid = 1'($urandom_range(0, 1));
        bus_rsp_rdata = $urandom;
        bus_rsp_err   = 1'($urandom_range(0, 1));
    endtask

    function automatic vec_t mk(input logic c, input logic w, input logic [3:0] m,
                                input logic [31:0] a, input logic [31:0] wd, input int rd,
                                input int sd, input logic e, input logic [31:0] r,
                                input logic xacc, input logic [31:0] xaddr,
                                input logic [3:0] xbe, input logic xwe,
                                input logic [31:0] xdata, input logic xerr);
        vec_t v;
        v.cs = c; v.wr = w; v.mask = m; v.addr = a; v.wdata = wd;
        v.rdy_dly = rd; v.rsp_dly = sd; v.err = e; v.rdata = r;
        v.exp_acc = xacc; v.exp_addr = xaddr; v.exp_be = xbe; v.exp_we = xwe;
        v.exp_data = xdata; v.exp_err = xerr;
        return v;
    endfunction

    // Reference model: one whole transaction's outcome from the access rules
    function automatic vec_t rand_vec(input logic [31:0] cur);
        vec_t v;
        v.cs      = ($urandom_range(0, 7) == 0);
        v.wr      = 1'($urandom_range(0, 1));
        v.mask    = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
        v.addr    = $urandom;
        v.wdata   = $urandom;
        v.rdata   = $urandom;
        v.rdy_dly = $urandom_range(0, MaxDly);
        v.rsp_dly = $urandom_range(0, MaxDly - v.rdy_dly);
        v.err     = v.wr && ($urandom_range(0, 3) == 0);
        v.exp_acc  = !v.cs && (v.wr || (v.mask != 4'b0000));
        v.exp_addr = v.addr - (v.addr % 32'd4);
        v.exp_be   = v.wr ? 4'b1111 : v.mask;
        v.exp_we   = !v.wr;
        if (v.exp_acc && v.wr) v.exp_data = v.err ? 32'h0 : v.rdata;
        else                   v.exp_data = cur;
        v.exp_err  = v.exp_acc && v.err;
        return v;
    endfunction

    // Entered just after a rising edge; leaves just after the edge that ends DONE
    task automatic run_txn(input vec_t v);
        cs = v.cs; wr = v.wr; mask = v.mask; addr = v.addr; data_wr = v.wdata;
        junk_bus();
        bus_req_ready = 1'b0;
        @(negedge clk);
        chk("idle_stall", stall, v.exp_acc);
        chk("idle_valid", bus_req_valid, 1'b0);
        chk("idle_err", access_err, 1'b0);
        chk("idle_data", data_rd, m_data_rd);
        next_cycle();
        if (!v.exp_acc) begin
            junk_bus();
            @(negedge clk);
            chk("noacc_valid", bus_req_valid, 1'b0);
            chk("noacc_stall", stall, 1'b0);
            chk("noacc_data", data_rd, v.exp_data);
            next_cycle();
            m_data_rd = v.exp_data;
            return;
        end
        for (int i = 0; i <= v.rdy_dly; i++) begin
            junk_bus();
            bus_req_ready = (i == v.rdy_dly);
            @(negedge clk);
            chk("req_valid", bus_req_valid, 1'b1);
            chk("req_we", bus_req_we, v.exp_we);
            chk("req_addr", bus_req_addr, v.exp_addr);
            chk("req_wdata", bus_req_wdata, v.wdata);
            chk("req_be", bus_req_be, v.exp_be);
            chk("req_stall", stall, 1'b1);
            chk("req_err", access_err, 1'b0);
            next_cycle();
        end
        for (int j = 0; j <= v.rsp_dly; j++) begin
            junk_bus();
            bus_rsp_valid = (j == v.rsp_dly);
            if (j == v.rsp_dly) begin
                bus_rsp_rdata = v.rdata;
                bus_rsp_err   = v.err;
            end
            @(negedge clk);
            chk("wait_valid", bus_req_valid, 1'b0);
            chk("wait_stall", stall, 1'b1);
            chk("wait_data", data_rd, m_data_rd);
            next_cycle();
        end
        junk_bus();
        @(negedge clk);
        chk("done_stall", stall, 1'b0);
        chk("done_valid", bus_req_valid, 1'b0);
        chk("done_err", access_err, v.exp_err);
        chk("done_data", data_rd, v.exp_data);
        next_cycle();
        m_data_rd = v.exp_data;
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            cs = 1'b1; wr = 1'($urandom_range(0, 1)); mask = 4'($urandom);
            junk_bus();
            @(negedge clk);
            chk("gap_stall", stall, 1'b0);
            chk("gap_err", access_err, 1'b0);
            chk("gap_data", data_rd, m_data_rd);
            next_cycle();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0] = mk(1'b0, 1'b1, 4'h0, 32'h0000_1006, 32'h0, 0, 0, 1'b0, 32'hCAFE_F00D,
                    1'b1, 32'h0000_1004, 4'hF, 1'b0, 32'hCAFE_F00D, 1'b0);
        tbl[1] = mk(1'b0, 1'b0, 4'h4, 32'h0000_2001, 32'h00AB_0000, 3, 0, 1'b0, 32'h1234_5678,
                    1'b1, 32'h0000_2000, 4'h4, 1'b1, 32'hCAFE_F00D, 1'b0);
        tbl[2] = mk(1'b0, 1'b0, 4'h0, 32'h0000_2004, 32'h5555_5555, 0, 0, 1'b0, 32'h0,
                    1'b0, 32'h0, 4'h0, 1'b1, 32'hCAFE_F00D, 1'b0);
        tbl[3] = mk(1'b1, 1'b1, 4'hF, 32'h0000_2008, 32'h0, 0, 0, 1'b0, 32'h0,
                    1'b0, 32'h0, 4'hF, 1'b0, 32'hCAFE_F00D, 1'b0);
        tbl[4] = mk(1'b0, 1'b1, 4'h0, 32'h0000_3000, 32'h0, 0, 1, 1'b1, 32'hFFFF_FFFF,
                    1'b1, 32'h0000_3000, 4'hF, 1'b0, 32'h0, 1'b1);
        tbl[5] = mk(1'b0, 1'b1, 4'h2, 32'h0000_00FF, 32'h0, 1, 1, 1'b0, 32'h0BAD_BEEF,
                    1'b1, 32'h0000_00FC, 4'hF, 1'b0, 32'h0BAD_BEEF, 1'b0);
        tbl[6] = mk(1'b0, 1'b0, 4'h3, 32'h0000_4003, 32'h0000_BEEF, 0, 2, 1'b0, 32'h7777_7777,
                    1'b1, 32'h0000_4000, 4'h3, 1'b1, 32'h0BAD_BEEF, 1'b0);

        rst_n = 1'b0; cs = 1'b1; wr = 1'b0; mask = 4'h0; addr = 32'h0; data_wr = 32'h0;
        bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rsp_rdata = 32'h0; bus_rsp_err = 1'b0;
        m_data_rd = 32'h0;
        #12;
        chk("rst_stall", stall, 1'b0);
        chk("rst_valid", bus_req_valid, 1'b0);
        chk("rst_data", data_rd, 32'h0);
        chk("rst_err", access_err, 1'b0);
        chk("rst_addr", bus_req_addr, 32'h0);
        next_cycle();
        rst_n = 1'b1;

        foreach (tbl[t]) run_txn(tbl[t]);
        idle_cycles(1);

        for (int n = 0; n < 60; n++) begin
            run_txn(rand_vec(m_data_rd));
            idle_cycles($urandom_range(0, 2));
        end

`ifdef DMEM_BUS_TIMEOUT_EN
        run_txn(mk(1'b0, 1'b1, 4'h0, 32'h0000_6000, 32'h0, 0, 0, 1'b0, 32'h1357_9BDF,
                   1'b1, 32'h0000_6000, 4'hF, 1'b0, 32'h1357_9BDF, 1'b0));
        cs = 1'b0; wr = 1'b1; mask = 4'h0; addr = 32'h0000_7000;
        bus_req_ready = 1'b0; bus_rsp_valid = 1'b0;
        @(negedge clk);
        chk("to_idle_stall", stall, 1'b1);
        next_cycle();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("to_req_valid", bus_req_valid, 1'b1);
            chk("to_req_stall", stall, 1'b1);
            next_cycle();
        end
        @(negedge clk);
        chk("to_done_valid", bus_req_valid, 1'b0);
        chk("to_done_stall", stall, 1'b0);
        chk("to_done_err", access_err, 1'b1);
        chk("to_done_data", data_rd, 32'h0);
        next_cycle();
        cs = 1'b1; bus_rsp_valid = 1'b1; bus_rsp_rdata = 32'hDEAD_BEEF; bus_rsp_err = 1'b0;
        @(negedge clk);
        chk("to_late_err", access_err, 1'b0);
        chk("to_late_stall", stall, 1'b0);
        chk("to_late_data", data_rd, 32'h0);
        next_cycle();
        bus_rsp_valid = 1'b0;
        @(negedge clk);
        chk("to_after_data", data_rd, 32'h0);
        chk("to_after_valid", bus_req_valid, 1'b0);
        next_cycle();
        m_data_rd = 32'h0;
`else
        run_txn(mk(1'b0, 1'b1, 4'h0, 32'h0000_6002, 32'h0, 8, 3, 1'b0, 32'h1357_9BDF,
                   1'b1, 32'h0000_6000, 4'hF, 1'b0, 32'h1357_9BDF, 1'b0));
`endif

        run_txn(mk(1'b0, 1'b1, 4'h0, 32'h0000_5550, 32'h0, 0, 0, 1'b0, 32'h600D_F00D,
                   1'b1, 32'h0000_5550, 4'hF, 1'b0, 32'h600D_F00D, 1'b0));
        cs = 1'b0; wr = 1'b1; mask = 4'h0; addr = 32'h0000_5554; data_wr = 32'h1111_2222;
        bus_req_ready = 1'b0; bus_rsp_valid = 1'b0;
        next_cycle();
        bus_req_ready = 1'b1;
        next_cycle();
        bus_req_ready = 1'b0;
        @(negedge clk);
        chk("rw_pre_stall", stall, 1'b1);
        chk("rw_pre_addr", bus_req_addr, 32'h0000_5554);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rw_stall", stall, 1'b0);
        chk("rw_valid", bus_req_valid, 1'b0);
        chk("rw_we", bus_req_we, 1'b0);
        chk("rw_addr", bus_req_addr, 32'h0);
        chk("rw_be", bus_req_be, 4'h0);
        chk("rw_data", data_rd, 32'h0);
        chk("rw_err", access_err, 1'b0);
        cs = 1'b1;
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rw_rel_stall", stall, 1'b0);
        chk("rw_rel_valid", bus_req_valid, 1'b0);
        next_cycle();
        m_data_rd = 32'h0;
        idle_cycles(1);
        run_txn(mk(1'b0, 1'b1, 4'h0, 32'h0000_8008, 32'h0, 1, 0, 1'b0, 32'hA5A5_5A5A,
                   1'b1, 32'h0000_8008, 4'hF, 1'b0, 32'hA5A5_5A5A, 1'b0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
